// File: rtl/seven_seg_scroller.sv
// Scrolls a message from a 16-entry segment register file across four digits, right to left.
// Define SCROLL_LOOP_EN to repeat the pass until STOP or CLR instead of ending after one pass.
module seven_seg_scroller #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       START,
    input  logic       STOP,
    input  logic [3:0] LEN,
    input  logic [6:0] DATA,
    output logic       RA3,
    output logic       RA2,
    output logic       RA1,
    output logic       RA0,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic       BUSY,
    output logic       DONE
);

    localparam int unsigned PTR_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned TICK_W = 16;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_LOAD = 2'd2,
        S_WAIT = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    len_q, len_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [SEG_W-1:0]    hex0_q, hex0_d;
    logic [SEG_W-1:0]    hex1_q, hex1_d;
    logic [SEG_W-1:0]    hex2_q, hex2_d;
    logic [SEG_W-1:0]    hex3_q, hex3_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tick_end_c;
    logic                last_c;

    assign tick_end_c = (tick_q == TICK_LAST);
    assign last_c     = (ptr_q == len_q);

    // State register
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; STOP overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (START) state_d = S_ADDR;
            S_ADDR: state_d = S_LOAD;
            S_LOAD: state_d = S_WAIT;
            S_WAIT: begin
                if (tick_end_c) begin
                    if (!last_c) begin
                        state_d = S_ADDR;
                    end else begin
`ifdef SCROLL_LOOP_EN
                        state_d = S_ADDR;
`else
                        state_d = S_IDLE;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (STOP) state_d = S_IDLE;
    end

    // Datapath and output next values
    always_comb begin
        ptr_d  = ptr_q;
        len_d  = len_q;
        tick_d = tick_q;
        hex0_d = hex0_q;
        hex1_d = hex1_q;
        hex2_d = hex2_q;
        hex3_d = hex3_q;
        done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    ptr_d  = '0;
                    len_d  = LEN;
                    hex0_d = '0;
                    hex1_d = '0;
                    hex2_d = '0;
                    hex3_d = '0;
                end
            end
            S_LOAD: begin
                hex3_d = hex2_q;
                hex2_d = hex1_q;
                hex1_d = hex0_q;
                hex0_d = DATA;
                tick_d = '0;
            end
            S_WAIT: begin
                tick_d = tick_q + TICK_W'(1);
                if (tick_end_c) begin
                    tick_d = '0;
                    if (!last_c) begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end else begin
                        ptr_d  = '0;
                        done_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (STOP) begin
            ptr_d  = '0;
            tick_d = '0;
            hex0_d = '0;
            hex1_d = '0;
            hex2_d = '0;
            hex3_d = '0;
            done_d = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (CLR) begin
            ptr_q  <= '0;
            len_q  <= '0;
            tick_q <= '0;
            hex0_q <= '0;
            hex1_q <= '0;
            hex2_q <= '0;
            hex3_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            len_q  <= len_d;
            tick_q <= tick_d;
            hex0_q <= hex0_d;
            hex1_q <= hex1_d;
            hex2_q <= hex2_d;
            hex3_q <= hex3_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign RA3  = ptr_q[3];
    assign RA2  = ptr_q[2];
    assign RA1  = ptr_q[1];
    assign RA0  = ptr_q[0];
    assign HEX0 = hex0_q;
    assign HEX1 = hex1_q;
    assign HEX2 = hex2_q;
    assign HEX3 = hex3_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_seven_seg_scroller.sv
// Directed bench for seven_seg_scroller (TICK_DIV=4): one-shot passes from a vector table,
// reset, STOP, mid-pass CLR and, when SCROLL_LOOP_EN is defined, continuous scrolling.
module tb_seven_seg_scroller;

    logic       CLK = 1'b0;
    logic       CLR, START, STOP;
    logic [3:0] LEN;
    logic [6:0] DATA;
    logic       RA3, RA2, RA1, RA0;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;
    logic       BUSY, DONE;

    logic [6:0] rf [16];
    logic [3:0] ra;
    logic [27:0] hex_all;

    int tests  = 0;
    int failed = 0;

    seven_seg_scroller #(.TICK_DIV(4)) dut (
        .CLK(CLK), .CLR(CLR), .START(START), .STOP(STOP), .LEN(LEN), .DATA(DATA),
        .RA3(RA3), .RA2(RA2), .RA1(RA1), .RA0(RA0),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    assign ra      = {RA3, RA2, RA1, RA0};
    assign DATA    = rf[ra];
    assign hex_all = {HEX3, HEX2, HEX1, HEX0};

    typedef struct {
        logic [3:0]  len;
        logic [6:0]  rf0;
        logic        mid_start;
        logic [27:0] exp_hex;
        int          exp_done;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_pass(input logic [3:0] len);
        LEN   = len;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   done_at, ra_bad, busy_bad, bad, dcnt;

        // Register file holds the digit code of i+1 (entry 15 wraps to '0').
        rf = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F,
               7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3F};

        vecs[0] = '{4'd3,  7'h06, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 24};
        vecs[1] = '{4'd0,  7'h3F, 1'b0, {7'h00, 7'h00, 7'h00, 7'h3F}, 6};
        vecs[2] = '{4'd1,  7'h06, 1'b0, {7'h00, 7'h00, 7'h06, 7'h5B}, 12};
        vecs[3] = '{4'd15, 7'h06, 1'b0, {7'h5E, 7'h79, 7'h71, 7'h3F}, 96};
        vecs[4] = '{4'd5,  7'h06, 1'b1, {7'h4F, 7'h66, 7'h6D, 7'h7D}, 36};

        // Reset held with START asserted: everything stays at zero
        CLR = 1'b1; START = 1'b1; STOP = 1'b0; LEN = 4'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_outputs", {2'b0, BUSY, DONE, ra, hex_all}, 32'h0);
        end
        CLR = 1'b0; START = 1'b0;
        tick();
        check("idle_after_reset", {2'b0, BUSY, DONE, ra, hex_all}, 32'h0);

`ifndef SCROLL_LOOP_EN
        for (int v = 0; v < 5; v++) begin
            rf[0] = vecs[v].rf0;
            start_pass(vecs[v].len);
            done_at = -1; ra_bad = 0; busy_bad = 0;
            if (ra != 4'd0 || !BUSY) ra_bad++;
            for (int n = 1; n <= 200 && done_at < 0; n++) begin
                tick();
                if (DONE) begin
                    done_at = n;
                    if (BUSY) busy_bad++;
                end else begin
                    if (!BUSY) busy_bad++;
                    if (ra != 4'(n / 6)) ra_bad++;
                end
                if (vecs[v].mid_start && n == 10) begin START = 1'b1; LEN = 4'd9; end
                if (vecs[v].mid_start && n == 11) begin START = 1'b0; end
            end
            check($sformatf("done_cycle_v%0d", v), 32'(done_at), 32'(vecs[v].exp_done));
            check($sformatf("ra_sequence_v%0d", v), 32'(ra_bad), 32'd0);
            check($sformatf("busy_v%0d", v), 32'(busy_bad), 32'd0);
            tick();
            check($sformatf("done_pulse_v%0d", v), {29'b0, DONE, BUSY, 1'b0}, 32'h0);
            tick();
            tick();
            check($sformatf("hex_held_v%0d", v), {4'b0, hex_all}, {4'b0, vecs[v].exp_hex});
            check($sformatf("ra_idle_v%0d", v), {28'b0, ra}, 32'h0);
        end
`else
        // Continuous scrolling of a two-character message
        rf[0] = 7'h06;
        start_pass(4'd1);
        bad = 0; dcnt = 0;
        for (int n = 1; n <= 48; n++) begin
            tick();
            if (!BUSY) bad++;
            if (ra != 4'((n / 6) % 2)) bad++;
            if (DONE != (n % 12 == 0)) bad++;
            if (DONE) dcnt++;
        end
        check("loop_sequence", 32'(bad), 32'd0);
        check("loop_done_count", 32'(dcnt), 32'd4);
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        check("loop_stop", {2'b0, BUSY, DONE, ra, hex_all}, 32'h0);
        tick();
`endif

        // STOP during the second WAIT of a LEN=5 pass
        rf[0] = 7'h06;
        start_pass(4'd5);
        for (int n = 1; n <= 9; n++) tick();
        check("pre_stop_hex", {4'b0, hex_all}, {4'b0, 7'h00, 7'h00, 7'h06, 7'h5B});
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        check("stop_abort", {2'b0, BUSY, DONE, ra, hex_all}, 32'h0);
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (DONE || BUSY) bad++;
        end
        check("stop_no_done", 32'(bad), 32'd0);
        START = 1'b1; STOP = 1'b1; LEN = 4'd2;
        tick();
        check("start_stop_idle", {31'b0, BUSY}, 32'h0);
        START = 1'b0; STOP = 1'b0;
        tick();
        check("start_stop_stay", {31'b0, BUSY}, 32'h0);

        // CLR in the middle of a pass
        start_pass(4'd3);
        for (int n = 1; n <= 10; n++) tick();
        check("pre_clr_busy", {31'b0, BUSY}, 32'h1);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        check("clr_abort", {2'b0, BUSY, DONE, ra, hex_all}, 32'h0);
        bad = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (DONE || BUSY) bad++;
        end
        check("clr_no_done", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
